// File: rtl/carregador_matrizes.sv
// rtl/carregador_matrizes.sv - serial byte loader assembling packed A/B matrices for the multiplier
// Optional A-reuse command (cfg_keep_a) enabled by defining CARREGADOR_REUSE_A_EN.
module carregador_matrizes #(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [1:0]                        cfg_size,
`ifdef CARREGADOR_REUSE_A_EN
    input  logic                              cfg_keep_a,
`endif
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_W-1:0]                 in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [MAX_N*MAX_N*DATA_W-1:0]     A,
    output logic [MAX_N*MAX_N*DATA_W-1:0]     B,
    output logic [1:0]                        matrix_size,
    output logic                              busy
);

    localparam int BUS_W = MAX_N * MAX_N * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_PRESENT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [BUS_W-1:0]   r_a;
    logic [BUS_W-1:0]   r_b;
    logic [1:0]         r_size;
    logic [4:0]         r_cnt;
    logic [4:0]         w_last_idx;
    logic [7:0]         w_base;
    logic               w_cfg_accept;
    logic               w_accept;
    logic               w_last;
    logic               w_keep;

    // Index of the final element (n*n-1) for the latched size.
    always_comb begin
        w_last_idx = 5'd3;
        case (r_size)
            2'b00:   w_last_idx = 5'd3;
            2'b01:   w_last_idx = 5'd8;
            2'b10:   w_last_idx = 5'd15;
            default: w_last_idx = 5'd24;
        endcase
    end

    assign w_cfg_accept = cfg_valid && (r_state == S_IDLE);
    assign w_accept     = in_valid && in_ready;
    assign w_last       = (r_cnt == w_last_idx);
    assign w_base       = 8'(r_cnt) * 8'(DATA_W);

`ifdef CARREGADOR_REUSE_A_EN
    // A is only reusable when the new command keeps the same dimension.
    assign w_keep = cfg_keep_a && (cfg_size == r_size);
`else
    assign w_keep = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cfg_valid) begin
                    w_next = w_keep ? S_LOAD_B : S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                if (in_valid && w_last) begin
                    w_next = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (in_valid && w_last) begin
                    w_next = S_PRESENT;
                end
            end
            default: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_size <= 2'b00;
            r_cnt  <= 5'd0;
        end else if (w_cfg_accept) begin
            r_size <= cfg_size;
            r_b    <= '0;
            r_cnt  <= 5'd0;
            if (!w_keep) begin
                r_a <= '0;
            end
        end else if (w_accept) begin
            if (r_state == S_LOAD_A) begin
                r_a[w_base +: DATA_W] <= in_data;
            end else begin
                r_b[w_base +: DATA_W] <= in_data;
            end
            r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
        end
    end

    assign cfg_ready   = (r_state == S_IDLE);
    assign in_ready    = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign out_valid   = (r_state == S_PRESENT);
    assign busy        = (r_state != S_IDLE);
    assign A           = r_a;
    assign B           = r_b;
    assign matrix_size = r_size;

endmodule

// File: tb/tb_carregador_matrizes.sv
// tb/tb_carregador_matrizes.sv - scoreboard bench for carregador_matrizes
module tb_carregador_matrizes;

    typedef struct {
        logic [199:0] a;
        logic [199:0] b;
        logic [1:0]   size;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [1:0]   cfg_size = 2'b00;
    logic         keep_a = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'h00;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [199:0] A;
    logic [199:0] B;
    logic [1:0]   matrix_size;
    logic         busy;

    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           n_acc = 0;
    sb_t          sb[$];
    sb_t          mon_e;
    logic [7:0]   va [25];
    logic [7:0]   vb [25];
    logic [199:0] model_a = '0;
    logic [1:0]   model_size = 2'b00;
    logic [199:0] cap_a;
    logic [199:0] cap_b;

    carregador_matrizes dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_size    (cfg_size),
`ifdef CARREGADOR_REUSE_A_EN
        .cfg_keep_a  (keep_a),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .A           (A),
        .B           (B),
        .matrix_size (matrix_size),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int cel(input int i, input int j, input int n);
        int s;
        s = 0;
        for (int k = 0; k < n; k++) begin
            s += int'($signed(A[8*(i*n+k) +: 8])) * int'($signed(B[8*(k*n+j) +: 8]));
        end
        return s;
    endfunction

    // Monitor: counts consumed elements and checks every presented result against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) n_acc++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_output", 200'(1), 200'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_A", A, mon_e.a);
                    chk("sb_B", B, mon_e.b);
                    chk("sb_size", 200'(matrix_size), 200'(mon_e.size));
                end
            end
        end
    end

    task automatic load(input logic [1:0] sz, input bit bub, input bit keep, input bit chk_lat);
        int n, nn, total, p, t, acc0;
        bit eff_keep;
        sb_t e;
        n  = int'(sz) + 2;
        nn = n * n;
`ifdef CARREGADOR_REUSE_A_EN
        eff_keep = keep && (sz == model_size);
`else
        eff_keep = 1'b0;
`endif
        e.a = eff_keep ? model_a : '0;
        e.b = '0;
        for (int k = 0; k < nn; k++) begin
            if (!eff_keep) e.a[8*k +: 8] = va[k];
            e.b[8*k +: 8] = vb[k];
        end
        e.size = sz;
        sb.push_back(e);
        model_a    = e.a;
        model_size = sz;
        total = eff_keep ? nn : 2 * nn;

        @(posedge clk); #1;
        p = cyc;
        acc0 = n_acc;
        cfg_valid = 1'b1;
        cfg_size  = sz;
        keep_a    = keep;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        keep_a    = 1'b0;
        for (int i = 0; i < total; i++) begin
            if (bub) begin
                in_valid = 1'b0;
                in_data  = 8'hEE;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            if (!eff_keep && i < nn) in_data = va[i];
            else in_data = vb[eff_keep ? i : i - nn];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        t = 0;
        while (!out_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("out_valid_seen", 200'(out_valid), 200'(1));
        if (chk_lat) chk("latency", 200'(cyc - p), 200'(1 + 2 * nn));
        chk("elements_consumed", 200'(n_acc - acc0), 200'(total));
        if (out_ready) begin
            @(posedge clk); #1;
            chk("idle_after_accept", 200'(cfg_ready), 200'(1));
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_A", A, '0);
        chk("rst_B", B, '0);
        chk("rst_size", 200'(matrix_size), 200'(0));
        chk("rst_out_valid", 200'(out_valid), 200'(0));
        chk("rst_in_ready", 200'(in_ready), 200'(0));
        chk("rst_cfg_ready", 200'(cfg_ready), 200'(1));
        chk("rst_busy", 200'(busy), 200'(0));

        // 2x2 back-to-back load
        for (int k = 0; k < 25; k++) begin va[k] = 8'(k + 1); vb[k] = 8'(k + 5); end
        load(2'b00, 1'b0, 1'b0, 1'b1);
        chk("2x2_A_low", 200'(A[31:0]), 200'(32'h04030201));
        chk("2x2_B_low", 200'(B[31:0]), 200'(32'h08070605));
        chk("2x2_c00", 200'(cel(0, 0, 2)), 200'(19));
        chk("2x2_c01", 200'(cel(0, 1, 2)), 200'(22));
        chk("2x2_c10", 200'(cel(1, 0, 2)), 200'(43));
        chk("2x2_c11", 200'(cel(1, 1, 2)), 200'(50));

        // 5x5 signed
        for (int k = 0; k < 25; k++) begin
            if (k < 12) va[k] = 8'(10 * (k + 1));
            else if (k == 12) va[k] = 8'h80;
            else if (k == 13) va[k] = 8'hC0;
            else if (k == 14) va[k] = 8'hE0;
            else va[k] = 8'(k - 20);
            vb[k] = 8'h01;
        end
        load(2'b11, 1'b0, 1'b0, 1'b1);
        chk("5x5_A_k12", 200'(A[103:96]), 200'(8'h80));
        chk("5x5_c20", 200'(cel(2, 0, 5)), 200'(6));

        // 3x3 with bubbles, then held in PRESENT with extra traffic that must be ignored
        for (int k = 0; k < 25; k++) begin va[k] = 8'(8'hA0 + k); vb[k] = 8'(8'h10 + k); end
        out_ready = 1'b0;
        load(2'b01, 1'b1, 1'b0, 1'b0);
        cap_a = A;
        cap_b = B;
        for (int h = 0; h < 5; h++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            in_data   = 8'h55;
            cfg_valid = 1'b1;
            cfg_size  = 2'b10;
            @(negedge clk);
            chk("hold_out_valid", 200'(out_valid), 200'(1));
            chk("hold_in_ready", 200'(in_ready), 200'(0));
            chk("hold_cfg_ready", 200'(cfg_ready), 200'(0));
            chk("hold_A", A, cap_a);
            chk("hold_B", B, cap_b);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_idle", 200'(cfg_ready), 200'(1));
        chk("hold_release_busy", 200'(busy), 200'(0));

        // Reset in the middle of loading B of a 4x4
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_size  = 2'b10;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        for (int i = 0; i < 19; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_a    = '0;
        model_size = 2'b00;
        @(negedge clk);
        chk("midrst_A", A, '0);
        chk("midrst_B", B, '0);
        chk("midrst_size", 200'(matrix_size), 200'(0));
        chk("midrst_cfg_ready", 200'(cfg_ready), 200'(1));
        chk("midrst_busy", 200'(busy), 200'(0));
        for (int k = 0; k < 25; k++) begin va[k] = 8'(k + 1); vb[k] = 8'(k + 5); end
        load(2'b00, 1'b0, 1'b0, 1'b1);

        // Size shrink: full 5x5 of 7F followed by a 2x2
        for (int k = 0; k < 25; k++) begin va[k] = 8'h7F; vb[k] = 8'h7F; end
        load(2'b11, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 25; k++) begin va[k] = 8'(k + 1); vb[k] = 8'(k + 5); end
        load(2'b00, 1'b0, 1'b0, 1'b0);
        chk("shrink_A_high", 200'(A[199:32]), '0);
        chk("shrink_B_high", 200'(B[199:32]), '0);

`ifdef CARREGADOR_REUSE_A_EN
        for (int k = 0; k < 25; k++) begin va[k] = 8'(k + 1); vb[k] = 8'h00; end
        load(2'b00, 1'b0, 1'b0, 1'b0);
        vb[0] = 8'd1; vb[1] = 8'd0; vb[2] = 8'd0; vb[3] = 8'd1;
        load(2'b00, 1'b0, 1'b1, 1'b0);
        chk("reuse_A", 200'(A[31:0]), 200'(32'h04030201));
        chk("reuse_c00", 200'(cel(0, 0, 2)), 200'(1));
        chk("reuse_c01", 200'(cel(0, 1, 2)), 200'(2));
        chk("reuse_c10", 200'(cel(1, 0, 2)), 200'(3));
        chk("reuse_c11", 200'(cel(1, 1, 2)), 200'(4));
        for (int k = 0; k < 25; k++) begin va[k] = 8'(k + 3); vb[k] = 8'(k + 40); end
        load(2'b01, 1'b0, 1'b1, 1'b1);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", 200'(sb.size()), 200'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
